// File: rtl/data_path_pkg.sv
// Shared widths, ALU opcode encoding and register-slot indices for the Mini SRC datapath.
package data_path_pkg;

    localparam int WORD_W = 32;
    localparam int Z_W    = 64;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_NOT  = 5'd4,
        OP_MUL  = 5'd5,
        OP_DIV  = 5'd6,
        OP_ROL  = 5'd7,
        OP_ROR  = 5'd8,
        OP_SHR  = 5'd9,
        OP_SHRA = 5'd10,
        OP_SHL  = 5'd11,
        OP_NEG  = 5'd12
    } alu_op_e;

    // Z is kept as two 32-bit slots so every register shares one implementation.
    localparam int IDX_R1  = 0;
    localparam int IDX_R2  = 1;
    localparam int IDX_R3  = 2;
    localparam int IDX_R4  = 3;
    localparam int IDX_R5  = 4;
    localparam int IDX_PC  = 5;
    localparam int IDX_IR  = 6;
    localparam int IDX_MAR = 7;
    localparam int IDX_MDR = 8;
    localparam int IDX_Y   = 9;
    localparam int IDX_HI  = 10;
    localparam int IDX_LO  = 11;
    localparam int IDX_ZLO = 12;
    localparam int IDX_ZHI = 13;
    localparam int NUM_REGS = 14;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from Y, B from the bus; the 64-bit result feeds only Z.
module data_path_alu
    import data_path_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [4:0]        opcode,
    input  logic              e_alu,
    input  logic              inc_pc,
    output logic [Z_W-1:0]    result
);

    alu_op_e                  op;
    logic [4:0]               sh;
    logic signed [Z_W-1:0]    product;
    logic signed [WORD_W-1:0] quotient;
    logic signed [WORD_W-1:0] remainder;
    logic [2*WORD_W-1:0]      rol_w;
    logic [2*WORD_W-1:0]      ror_w;
    logic signed [WORD_W-1:0] shra_w;

    assign op        = alu_op_e'(opcode);
    assign sh        = b[4:0];
    assign product   = $signed({{WORD_W{a[WORD_W-1]}}, a}) * $signed({{WORD_W{b[WORD_W-1]}}, b});
    assign quotient  = $signed(a) / $signed(b);
    assign remainder = $signed(a) % $signed(b);
    // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
    assign rol_w     = {a, a} << sh;
    assign ror_w     = {a, a} >> sh;
    assign shra_w    = $signed(a) >>> sh;

    always_comb begin
        result = '0;
        if (inc_pc) begin
            result = {{WORD_W{1'b0}}, b + 32'd1};
        end else if (e_alu) begin
            case (op)
                OP_ADD:  result = {{WORD_W{1'b0}}, a + b};
                OP_SUB:  result = {{WORD_W{1'b0}}, a - b};
                OP_AND:  result = {{WORD_W{1'b0}}, a & b};
                OP_OR:   result = {{WORD_W{1'b0}}, a | b};
                OP_NOT:  result = {{WORD_W{1'b0}}, ~b};
                OP_MUL:  result = product;
                OP_DIV: begin
                    if (b == '0) begin
                        result = {a, 32'hFFFF_FFFF};
                    end else begin
                        result = {remainder, quotient};
                    end
                end
                OP_ROL:  result = {{WORD_W{1'b0}}, rol_w[2*WORD_W-1:WORD_W]};
                OP_ROR:  result = {{WORD_W{1'b0}}, ror_w[WORD_W-1:0]};
                OP_SHR:  result = {{WORD_W{1'b0}}, a >> sh};
                OP_SHRA: result = {{WORD_W{1'b0}}, shra_w};
                OP_SHL:  result = {{WORD_W{1'b0}}, a << sh};
                OP_NEG:  result = {{WORD_W{1'b0}}, 32'd0 - b};
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus Mini SRC datapath: register slice, PC/IR/MAR/MDR/Y/Z/HI/LO and ALU on one shared bus.
module data_path
    import data_path_pkg::*;
(
    input  logic        w_clock,
    input  logic        w_clear,
    input  logic        w_IncPC,
    input  logic        e_R1,
    input  logic        e_R2,
    input  logic        e_R3,
    input  logic        e_R4,
    input  logic        e_R5,
    input  logic        e_MAR,
    input  logic        e_PC,
    input  logic        e_IR,
    input  logic        e_Y,
    input  logic        e_HI,
    input  logic        e_LO,
    input  logic        e_MDR,
    input  logic        e_Z,
    input  logic        s_PC,
    input  logic        s_Zlow,
    input  logic        s_MDR,
    input  logic        s_R2,
    input  logic        s_R3,
    input  logic        s_R4,
    input  logic        s_R5,
    input  logic        w_read,
    input  logic [5:0]  opcode,
    input  logic        e_alu,
    input  logic [31:0] w_Mdatain,
    output logic [31:0] o_bus
);

    logic [WORD_W-1:0]   reg_file_reg [NUM_REGS];
    logic [WORD_W-1:0]   reg_next     [NUM_REGS];
    logic [NUM_REGS-1:0] reg_en;
    logic [WORD_W-1:0]   bus;
    logic [WORD_W-1:0]   mdr_in;
    logic [Z_W-1:0]      alu_result;
    logic                opcode_unused;

    assign opcode_unused = opcode[5];

    always_comb begin
        bus = '0;
        if (s_MDR)       bus = reg_file_reg[IDX_MDR];
        else if (s_Zlow) bus = reg_file_reg[IDX_ZLO];
        else if (s_PC)   bus = reg_file_reg[IDX_PC];
        else if (s_R2)   bus = reg_file_reg[IDX_R2];
        else if (s_R3)   bus = reg_file_reg[IDX_R3];
        else if (s_R4)   bus = reg_file_reg[IDX_R4];
        else if (s_R5)   bus = reg_file_reg[IDX_R5];
    end

    assign o_bus  = bus;
    assign mdr_in = w_read ? w_Mdatain : bus;

    assign reg_en[IDX_R1]  = e_R1;
    assign reg_en[IDX_R2]  = e_R2;
    assign reg_en[IDX_R3]  = e_R3;
    assign reg_en[IDX_R4]  = e_R4;
    assign reg_en[IDX_R5]  = e_R5;
    assign reg_en[IDX_PC]  = e_PC;
    assign reg_en[IDX_IR]  = e_IR;
    assign reg_en[IDX_MAR] = e_MAR;
    assign reg_en[IDX_MDR] = e_MDR;
    assign reg_en[IDX_Y]   = e_Y;
    assign reg_en[IDX_HI]  = e_HI;
    assign reg_en[IDX_LO]  = e_LO;
    assign reg_en[IDX_ZLO] = e_Z;
    assign reg_en[IDX_ZHI] = e_Z;

    // Everything loads from the bus except MDR (mux) and the two Z halves (ALU).
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_next[i] = bus;
        end
        reg_next[IDX_MDR] = mdr_in;
        reg_next[IDX_ZLO] = alu_result[WORD_W-1:0];
        reg_next[IDX_ZHI] = alu_result[Z_W-1:WORD_W];
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge w_clock) begin
                if (w_clear) begin
                    reg_file_reg[gi] <= '0;
                end else if (reg_en[gi]) begin
                    reg_file_reg[gi] <= reg_next[gi];
                end
            end
        end
    endgenerate

    data_path_alu u_alu (
        .a      (reg_file_reg[IDX_Y]),
        .b      (bus),
        .opcode (opcode[4:0]),
        .e_alu  (e_alu),
        .inc_pc (w_IncPC),
        .result (alu_result)
    );

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: expectations queued with the stimulus, popped when the result is observable.
module tb_data_path;
    import data_path_pkg::*;

    logic        w_clock = 1'b0;
    logic        w_clear, w_IncPC;
    logic        e_R1, e_R2, e_R3, e_R4, e_R5;
    logic        e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO, e_MDR, e_Z;
    logic        s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5;
    logic        w_read, e_alu;
    logic [5:0]  opcode;
    logic [31:0] w_Mdatain;
    logic [31:0] o_bus;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] exp_q  [$];
    string       name_q [$];
    int          idx_q  [$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic        alu_en;
        logic        inc;
        logic [63:0] expv;
    } alu_case_t;

    alu_case_t cases      [$];
    string     case_names [$];

    logic [31:0] regs_view [NUM_REGS];

    data_path dut (
        .w_clock(w_clock), .w_clear(w_clear), .w_IncPC(w_IncPC),
        .e_R1(e_R1), .e_R2(e_R2), .e_R3(e_R3), .e_R4(e_R4), .e_R5(e_R5),
        .e_MAR(e_MAR), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_HI(e_HI), .e_LO(e_LO),
        .e_MDR(e_MDR), .e_Z(e_Z),
        .s_PC(s_PC), .s_Zlow(s_Zlow), .s_MDR(s_MDR),
        .s_R2(s_R2), .s_R3(s_R3), .s_R4(s_R4), .s_R5(s_R5),
        .w_read(w_read), .opcode(opcode), .e_alu(e_alu),
        .w_Mdatain(w_Mdatain), .o_bus(o_bus)
    );

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_view
            assign regs_view[gi] = dut.reg_file_reg[gi];
        end
    endgenerate

    always #5 w_clock = ~w_clock;

    task automatic idle();
        w_clear = 0; w_IncPC = 0;
        e_R1 = 0; e_R2 = 0; e_R3 = 0; e_R4 = 0; e_R5 = 0;
        e_MAR = 0; e_PC = 0; e_IR = 0; e_Y = 0; e_HI = 0; e_LO = 0; e_MDR = 0; e_Z = 0;
        s_PC = 0; s_Zlow = 0; s_MDR = 0; s_R2 = 0; s_R3 = 0; s_R4 = 0; s_R5 = 0;
        w_read = 0; e_alu = 0; opcode = '0; w_Mdatain = '0;
    endtask

    task automatic step();
        @(posedge w_clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle();
        w_read = 1; e_MDR = 1; w_Mdatain = v;
        step();
        idle();
    endtask

    task automatic push_reg(input int idx, input logic [31:0] v, input string n);
        exp_q.push_back({32'b0, v});
        name_q.push_back(n);
        idx_q.push_back(idx);
    endtask

    task automatic test_reset();
        logic [63:0] e;
        string       n;
        int          k;
        load_mdr(32'hA5A5_0001);
        s_MDR = 1; w_IncPC = 1; e_Z = 1;
        e_R1 = 1; e_R2 = 1; e_R3 = 1; e_R4 = 1; e_R5 = 1;
        e_PC = 1; e_IR = 1; e_MAR = 1; e_Y = 1; e_HI = 1; e_LO = 1;
        push_reg(IDX_ZLO, 32'hA5A5_0002, "preload_zlo");
        push_reg(IDX_LO, 32'hA5A5_0001, "preload_lo");
        step();
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); k = idx_q.pop_front();
            compared++;
            if ({32'b0, regs_view[k]} !== e) begin
                mismatched++;
                $display("FAIL %s: got %h want %h", n, regs_view[k], e[31:0]);
            end
        end
        // Clear while every enable (including MDR from Mdatain) is still active.
        e_MDR = 1; w_read = 1; w_Mdatain = 32'h1234_5678; w_clear = 1;
        for (int i = 0; i < NUM_REGS; i++) push_reg(i, 32'h0, $sformatf("reset_reg%0d", i));
        step();
        idle();
        for (int i = 0; i < NUM_REGS; i++) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); k = idx_q.pop_front();
            compared++;
            if ({32'b0, regs_view[k]} !== e) begin
                mismatched++;
                $display("FAIL %s: got %h want %h", n, regs_view[k], e[31:0]);
            end
        end
        s_MDR = 1; #1;
        compared++;
        if (o_bus !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_bus_mdr: got %h want %h", o_bus, 32'h0);
        end
        idle();
        $display("test_reset done");
    endtask

    task automatic test_load_path();
        logic [63:0] e;
        string       n;
        load_mdr(32'd7);
        s_MDR = 1; e_R2 = 1; #1;
        exp_q.push_back(64'd7); name_q.push_back("load_bus");
        e = exp_q.pop_front(); n = name_q.pop_front();
        compared++;
        if ({32'b0, o_bus} !== e) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", n, o_bus, e[31:0]);
        end
        exp_q.push_back(64'd7); name_q.push_back("load_r2");
        step();
        idle();
        e = exp_q.pop_front(); n = name_q.pop_front();
        compared++;
        if ({32'b0, regs_view[IDX_R2]} !== e) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", n, regs_view[IDX_R2], e[31:0]);
        end
        $display("test_load_path done");
    endtask

    task automatic test_add_sequence();
        logic [63:0] e;
        string       n;
        int          k;
        idle(); w_clear = 1; step(); idle();
        load_mdr(32'd7); s_MDR = 1; e_R2 = 1; step();
        load_mdr(32'd3); s_MDR = 1; e_R3 = 1; step();
        idle();
        push_reg(IDX_PC, 32'h1, "add_pc");
        push_reg(IDX_MAR, 32'h0, "add_mar");
        push_reg(IDX_IR, 32'h2891_8000, "add_ir");
        push_reg(IDX_Y, 32'h7, "add_y");
        push_reg(IDX_R1, 32'h0000_000A, "add_r1");
        push_reg(IDX_LO, 32'h0000_000A, "add_lo");
        push_reg(IDX_ZHI, 32'h0, "add_zhi");
        s_PC = 1; e_MAR = 1; w_IncPC = 1; e_Z = 1; step(); idle();
        s_Zlow = 1; e_PC = 1; w_read = 1; w_Mdatain = 32'h2891_8000; e_MDR = 1; step(); idle();
        s_MDR = 1; e_IR = 1; step(); idle();
        s_R2 = 1; e_Y = 1; step(); idle();
        s_R3 = 1; opcode = {1'b0, OP_ADD}; e_alu = 1; e_Z = 1; step(); idle();
        s_Zlow = 1; e_R1 = 1; e_LO = 1; step(); idle();
        while (idx_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); k = idx_q.pop_front();
            compared++;
            if ({32'b0, regs_view[k]} !== e) begin
                mismatched++;
                $display("FAIL %s: got %h want %h", n, regs_view[k], e[31:0]);
            end
        end
        $display("test_add_sequence done");
    endtask

    task automatic test_alu_ops();
        logic [63:0] e;
        logic [63:0] act;
        string       n;
        cases.delete(); case_names.delete();
        cases.push_back('{32'hFFFF_FFFA, 32'd4, {1'b0, OP_MUL}, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFE8}); case_names.push_back("mul");
        cases.push_back('{32'hFFFF_FFFA, 32'd4, {1'b0, OP_DIV}, 1'b1, 1'b0, 64'hFFFF_FFFE_FFFF_FFFF}); case_names.push_back("div");
        cases.push_back('{32'hFFFF_FFFA, 32'd0, {1'b0, OP_DIV}, 1'b1, 1'b0, 64'hFFFF_FFFA_FFFF_FFFF}); case_names.push_back("div0");
        cases.push_back('{32'd7, 32'hFFFF_FFFE, {1'b0, OP_DIV}, 1'b1, 1'b0, 64'h0000_0001_FFFF_FFFD}); case_names.push_back("div_neg_b");
        cases.push_back('{32'h8000_0001, 32'd1, {1'b0, OP_ROL}, 1'b1, 1'b0, 64'h0000_0003}); case_names.push_back("rol");
        cases.push_back('{32'h8000_0001, 32'd1, {1'b0, OP_ROR}, 1'b1, 1'b0, 64'hC000_0000}); case_names.push_back("ror");
        cases.push_back('{32'h8000_0001, 32'd1, {1'b0, OP_SHR}, 1'b1, 1'b0, 64'h4000_0000}); case_names.push_back("shr");
        cases.push_back('{32'h8000_0001, 32'd1, {1'b0, OP_SHRA}, 1'b1, 1'b0, 64'hC000_0000}); case_names.push_back("shra");
        cases.push_back('{32'h8000_0001, 32'd1, {1'b0, OP_SHL}, 1'b1, 1'b0, 64'h0000_0002}); case_names.push_back("shl");
        cases.push_back('{32'h1234_5678, 32'h24, {1'b0, OP_ROL}, 1'b1, 1'b0, 64'h2345_6781}); case_names.push_back("rol_b5bits");
        cases.push_back('{32'h1234_5678, 32'd8, {1'b0, OP_ROR}, 1'b1, 1'b0, 64'h7812_3456}); case_names.push_back("ror8");
        cases.push_back('{32'h4000_0000, 32'd4, {1'b0, OP_SHRA}, 1'b1, 1'b0, 64'h0400_0000}); case_names.push_back("shra_pos");
        cases.push_back('{32'hFFFF_FFFF, 32'd2, {1'b0, OP_ADD}, 1'b1, 1'b0, 64'h0000_0001}); case_names.push_back("add_wrap");
        cases.push_back('{32'd3, 32'd5, {1'b0, OP_SUB}, 1'b1, 1'b0, 64'hFFFF_FFFE}); case_names.push_back("sub");
        cases.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, {1'b0, OP_AND}, 1'b1, 1'b0, 64'h00F0_00F0}); case_names.push_back("and");
        cases.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, {1'b0, OP_OR}, 1'b1, 1'b0, 64'hFFF0_FFF0}); case_names.push_back("or");
        cases.push_back('{32'h0, 32'h0FF0_0FF0, {1'b0, OP_NOT}, 1'b1, 1'b0, 64'hF00F_F00F}); case_names.push_back("not");
        cases.push_back('{32'h0, 32'd5, {1'b0, OP_NEG}, 1'b1, 1'b0, 64'hFFFF_FFFB}); case_names.push_back("neg");
        cases.push_back('{32'd10, 32'd20, 6'd32, 1'b1, 1'b0, 64'h0000_001E}); case_names.push_back("add_op5_ignored");
        cases.push_back('{32'd10, 32'd20, 6'd20, 1'b1, 1'b0, 64'h0}); case_names.push_back("unused_op20");
        cases.push_back('{32'd1, 32'd2, {1'b0, OP_ADD}, 1'b0, 1'b0, 64'h0}); case_names.push_back("alu_disabled");
        cases.push_back('{32'd5, 32'hFFFF_FFFF, {1'b0, OP_ADD}, 1'b1, 1'b1, 64'h0}); case_names.push_back("incpc_wrap");
        cases.push_back('{32'd5, 32'd9, {1'b0, OP_MUL}, 1'b0, 1'b1, 64'h0000_000A}); case_names.push_back("incpc_override");
        for (int i = 0; i < cases.size(); i++) begin
            load_mdr(cases[i].a);
            s_MDR = 1; e_Y = 1; step();
            load_mdr(cases[i].b);
            s_MDR = 1; opcode = cases[i].op; e_alu = cases[i].alu_en; w_IncPC = cases[i].inc; e_Z = 1;
            exp_q.push_back(cases[i].expv); name_q.push_back(case_names[i]);
            step();
            idle();
            e = exp_q.pop_front(); n = name_q.pop_front();
            act = {regs_view[IDX_ZHI], regs_view[IDX_ZLO]};
            compared++;
            if (act !== e) begin
                mismatched++;
                $display("FAIL %s: got %h want %h", n, act, e);
            end
            s_Zlow = 1; #1;
            compared++;
            if (o_bus !== e[31:0]) begin
                mismatched++;
                $display("FAIL %s_zlow_bus: got %h want %h", n, o_bus, e[31:0]);
            end
            idle();
            $display("alu case %s: z=%h", n, act);
        end
    endtask

    task automatic test_bus_priority();
        load_mdr(32'h44); s_MDR = 1; e_PC = 1; step();
        load_mdr(32'h11); s_MDR = 1; e_R2 = 1; step();
        load_mdr(32'h22); s_MDR = 1; e_R5 = 1; step();
        load_mdr(32'h33);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] e;
            idle();
            case (i)
                0: e = 32'h0;
                1: begin s_MDR = 1; s_PC = 1; e = 32'h33; end
                2: begin s_PC = 1; s_R2 = 1; e = 32'h44; end
                3: begin s_R2 = 1; s_R5 = 1; e = 32'h11; end
                default: begin s_R5 = 1; e = 32'h22; end
            endcase
            #1;
            compared++;
            if (o_bus !== e) begin
                mismatched++;
                $display("FAIL bus_prio%0d: got %h want %h", i, o_bus, e);
            end
        end
        idle();
        $display("test_bus_priority done");
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        string       n;
        int          k;
        load_mdr(32'hDEAD_BEEF);
        s_MDR = 1; e_R2 = 1; w_read = 1; w_Mdatain = 32'h1234_5678; e_MDR = 1; step(); idle();
        s_R2 = 1; e_R3 = 1; step(); idle();
        s_R3 = 1; e_R4 = 1; e_R5 = 1; step(); idle();
        push_reg(IDX_R2, 32'hDEAD_BEEF, "b2b_r2");
        push_reg(IDX_MDR, 32'h1234_5678, "b2b_mdr");
        push_reg(IDX_R3, 32'hDEAD_BEEF, "b2b_r3");
        push_reg(IDX_R4, 32'hDEAD_BEEF, "b2b_r4");
        push_reg(IDX_R5, 32'hDEAD_BEEF, "b2b_r5");
        while (idx_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); k = idx_q.pop_front();
            compared++;
            if ({32'b0, regs_view[k]} !== e) begin
                mismatched++;
                $display("FAIL %s: got %h want %h", n, regs_view[k], e[31:0]);
            end
        end
        // MDR loading from the bus when w_read is low.
        s_R4 = 1; e_MDR = 1; w_read = 0; w_Mdatain = 32'h5555_5555; step(); idle();
        s_MDR = 1; #1;
        compared++;
        if (o_bus !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL mdr_from_bus: got %h want %h", o_bus, 32'hDEAD_BEEF);
        end
        idle();
        $display("test_back_to_back done");
    endtask

    initial begin
        idle();
        w_clear = 1;
        step();
        step();
        idle();
        test_reset();
        test_load_path();
        test_add_sequence();
        test_alu_ops();
        test_bus_priority();
        test_back_to_back();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d want %0d", exp_q.size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
